// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM burst-to-stream reader.
// Holds the control FSM state encoding.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo_2.sv
// Two-entry synchronous FIFO with the head always held in slot 0.
// The head register only changes on a pop or a write into an empty FIFO.
module sync_fifo_2 #(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_count;
    logic             w_rd;
    logic             w_slot;

    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem0;
    assign w_rd      = i_rd_en & ~o_empty;

    // Slot the incoming word lands in once any pop has shifted the queue
    assign w_slot = (r_count == 2'd2) ||
                    ((r_count == 2'd1) && !w_rd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_rd)
                r_mem0 <= r_mem1;
            if (i_wr_en) begin
                if (w_slot)
                    r_mem1 <= i_wr_data;
                else
                    r_mem0 <= i_wr_data;
            end
            r_count <= r_count + {1'b0, i_wr_en} - {1'b0, w_rd};
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: pulls words from a registered-output RAM and
// presents them as a valid/ready stream with a last-beat marker.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready
);

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;
    logic                  w_rd_en;
    logic                  w_pop;
    logic                  w_empty;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic [DATA_WIDTH:0]   w_head;

    assign w_pop    = o_tvalid & i_tready;
    assign o_tvalid = ~w_empty;
    assign o_tdata  = w_head[DATA_WIDTH-1:0];
    assign o_tlast  = w_head[DATA_WIDTH] & o_tvalid;
    assign o_busy   = (r_state != IDLE);
    assign o_done   = r_done;
    assign o_rd_en  = w_rd_en;
    assign o_rd_addr = r_addr;

    // Words already owed to the FIFO after this cycle's transfer
    assign w_occ = {1'b0, w_count} + {2'b0, r_inflight}
                 - {2'b0, w_pop};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start && (i_length != '0))
                    w_next = READ;
            end
            READ: begin
                w_rd_en = (w_occ < 3'd2);
                if (w_rd_en && (r_remaining == LEN_ONE))
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (w_pop && o_tlast)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && (r_remaining == LEN_ONE);
            if ((r_state == IDLE) && i_start) begin
                if (i_length == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_addr      <= i_base_addr;
                    r_remaining <= i_length;
                end
            end else if (w_rd_en) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_remaining <= r_remaining - LEN_ONE;
            end
            if ((r_state == DRAIN) && w_pop && o_tlast)
                r_done <= 1'b1;
        end
    end

    sync_fifo_2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_inflight),
        .i_wr_data ({r_inflight_last, i_rd_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural RAM,
// burst-level reference model and randomized bursts/backpressure.
module tb_ram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    always #5 clk = ~clk;

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .i_length    (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_tdata     (tdata),
        .o_tvalid    (tvalid),
        .o_tlast     (tlast),
        .i_tready    (tready)
    );

    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk)
        if (rd_en)
            rd_data <= mem[rd_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding burst, expected beats in a queue
    logic [DW:0]   exp_q [$];
    bit            m_busy     = 0;
    int            m_len      = 0;
    int            m_issued   = 0;
    int            m_xfer     = 0;
    int            m_cyc      = 0;
    logic [AW-1:0] m_addr     = '0;
    bit            m_full_rdy = 0;
    bit            exp_done   = 0;
    bit            chk_zero   = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin : mon
        bit            pop;
        bit            busy_pre;
        bit            done_next;
        logic [DW:0]   e;
        logic [AW-1:0] a;
        if (chk_zero) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_en", rd_en, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_tvalid", tvalid, 0);
            check("rst_tlast", tlast, 0);
            check("rst_tdata", tdata, 0);
        end
        if (rst) begin
            exp_q.delete();
            m_busy     = 0;
            exp_done   = 0;
            prev_stall = 0;
            chk_zero   = 1;
        end else begin
            chk_zero  = 0;
            pop       = tvalid && tready;
            busy_pre  = m_busy;
            done_next = 0;
            check("busy", busy, m_busy);
            check("done", done, exp_done);
            if (!busy_pre) begin
                check("idle_rd_en", rd_en, 0);
                check("idle_tvalid", tvalid, 0);
            end
            if (prev_stall) begin
                check("stall_valid", tvalid, 1);
                check("stall_data", tdata, prev_data);
                check("stall_last", tlast, prev_last);
            end
            if (busy_pre) begin
                m_cyc++;
                if (!tready)
                    m_full_rdy = 0;
            end
            if (rd_en && busy_pre) begin
                check("rd_addr", rd_addr, m_addr);
                check("rd_pending", (m_issued - m_xfer - int'(pop)) < 2, 1);
                check("rd_count", m_issued < m_len, 1);
                if (m_issued == 0)
                    check("rd_latency", m_cyc, 1);
                m_issued++;
                m_addr++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got %0h expected none", tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tdata, e[DW-1:0]);
                    check("beat_last", tlast, e[DW]);
                    if (m_full_rdy)
                        check("beat_time", m_cyc, 3 + m_xfer);
                    if (e[DW]) begin
                        m_busy    = 0;
                        done_next = 1;
                    end
                end
                m_xfer++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (start && !busy_pre) begin
                if (len == '0) begin
                    done_next = 1;
                end else begin
                    m_busy     = 1;
                    m_len      = int'(len);
                    m_issued   = 0;
                    m_xfer     = 0;
                    m_cyc      = 0;
                    m_addr     = base;
                    m_full_rdy = 1;
                    a          = base;
                    for (int k = 0; k < m_len; k++) begin
                        exp_q.push_back({k == m_len - 1, mem[a]});
                        a++;
                    end
                end
            end
            exp_done = done_next;
        end
    end

    // Sink backpressure: 0 always ready, 1 pattern 1,0,0,1, 2 random
    int mode = 0;
    int pidx = 0;

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pidx++;
            case (mode)
                0: tready = 1'b1;
                1: tready = (pidx % 4 == 0) || (pidx % 4 == 3);
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic burst(input logic [AW-1:0] b, input logic [AW:0] l,
                         input int ign);
        int c;
        bit ok;
        int bound;
        c     = 0;
        ok    = 0;
        bound = int'(l) * 4 + 20;
        start = 1'b1;
        base  = b;
        len   = l;
        @(posedge clk);
        #1;
        while (c < bound) begin
            if (done) begin
                ok = 1;
                break;
            end
            start = (c == ign);
            if (start) begin
                base = AW'($urandom);
                len  = (AW + 1)'($urandom_range(1, 9));
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got none expected done base %0h len %0d",
                     b, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        mode = 0;
        burst(8'h10, 9'd4, -1);
        burst(8'hFE, 9'd4, -1);
        mode = 1;
        burst(8'h30, 9'd8, -1);
        mode = 0;
        burst(8'h55, 9'd0, -1);
        burst(8'h20, 9'd6, 2);

        start = 1'b1;
        base  = 8'h40;
        len   = 9'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        w = 0;
        while (m_xfer < 3 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("xfer_before_reset", m_xfer >= 3, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        burst(8'h00, 9'd2, -1);

        burst(AW'($urandom), 9'd256, -1);

        for (int it = 0; it < 25; it++) begin
            if (it == 5)
                for (int i = 0; i < DEPTH; i++)
                    mem[i] = DW'($urandom);
            mode = $urandom_range(0, 2);
            burst(AW'($urandom),
                  ($urandom_range(0, 4) == 0) ? 9'd0 :
                      (AW + 1)'($urandom_range(1, 40)),
                  ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(0, 2)) : -1);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: RAM word and stream beat width in bits, multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8: RAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 i_clk  input  1  single clock for all logic.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle request to begin a burst read.
REQ-006 i_base_addr  input  ADDR_WIDTH  first word address of the burst, sampled with i_start.
REQ-007 i_length  input  ADDR_WIDTH+1  burst length in words (0..2**ADDR_WIDTH), sampled with i_start.
REQ-008 o_busy  output  1  high from the accepted start until the burst completes.
REQ-009 o_done  output  1  one-cycle completion pulse.
REQ-010 o_rd_en  output  1  read enable to the RAM read port.
REQ-011 o_rd_addr  output  ADDR_WIDTH  read address to the RAM read port.
REQ-012 i_rd_data  input  DATA_WIDTH  RAM read data, valid exactly one cycle after o_rd_en (registered-output RAM).
REQ-013 o_tdata  output  DATA_WIDTH  stream beat data.
REQ-014 o_tvalid  output  1  stream beat valid.
REQ-015 o_tlast  output  1  marks the final beat of the burst.
REQ-016 i_tready  input  1  stream sink ready; a beat transfers when o_tvalid and i_tready are both high.

Function
REQ-017 FSM states IDLE, READ, DRAIN; i_start is accepted only in IDLE and is ignored otherwise.
REQ-018 IDLE -> READ on i_start with i_length > 0; latch base address and length, assert o_busy the next cycle.
REQ-019 i_start with i_length = 0 stays in IDLE, produces no beats and pulses o_done the next cycle.
REQ-020 In READ, o_rd_en is asserted only when (buffered beats + reads in flight - beat transferring this cycle) < 2.
REQ-021 o_rd_addr starts at i_base_addr and increments by 1 per issued read, wrapping modulo 2**ADDR_WIDTH.
REQ-022 READ -> DRAIN in the cycle after the last read is issued; no o_rd_en in DRAIN or IDLE.
REQ-023 Each i_rd_data word is captured into a 2-entry FIFO the cycle after its read; FIFO never overflows.
REQ-024 o_tvalid = FIFO not empty; o_tdata = FIFO head; o_tdata and o_tlast hold stable while o_tvalid and not i_tready.
REQ-025 o_tlast is high only on the beat carrying the i_length-th word.
REQ-026 Latency: start accepted at edge N -> o_rd_en high cycle N+1 -> first o_tvalid cycle N+3.
REQ-027 With i_tready held high, one beat transfers every cycle after the first (full throughput).
REQ-028 On the o_tlast handshake: DRAIN -> IDLE, o_busy low and o_done high in the following cycle.
REQ-029 A new i_start in the same cycle o_done is high is accepted.

Reset
REQ-030 i_rst high at any clock edge: state IDLE, FIFO and in-flight count cleared; in-flight RAM data is discarded.
REQ-031 Output values during and after reset: o_busy, o_done, o_rd_en, o_tvalid, o_tlast = 0; o_rd_addr, o_tdata = 0.

Structure
REQ-032 FSM state enum (IDLE, READ, DRAIN) shall be defined in package ram_stream_reader_pkg.
REQ-033 The 2-entry buffer shall be a separate sub-module sync_fifo_2 (DATA_WIDTH+1 bits wide: data plus last flag).
REQ-034 Total RTL including sub-module shall be 120-400 lines.

Verification
REQ-035 RAM preloaded with mem[i]=i; start base=0x10, length=4, i_tready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, o_tlast on 0x13, o_done one cycle later.
REQ-036 base=0xFE, length=4 (ADDR_WIDTH=8) -> beats 0xFE,0xFF,0x00,0x01 (address wrap).
REQ-037 length=8, i_tready toggling 1,0,0,1 pattern -> all 8 beats in order, none duplicated or lost, o_tdata stable while stalled, o_rd_en never asserted with 2 entries pending.
REQ-038 i_start with length=0 -> no o_tvalid, o_done pulse next cycle; i_start while busy -> ignored, burst unaffected.
REQ-039 i_rst asserted after 3 of 8 beats -> all outputs 0 next cycle; subsequent start base=0, length=2 -> beats 0x00,0x01 only.
REQ-040 length=256 full-depth burst, i_tready=1 -> 256 beats in 256 consecutive cycles, o_tlast on beat 256.
